// File: rtl/iob_wishbone2iob_pkg.sv
// Shared definitions for the Wishbone-to-IOb bridge: FSM state encodings and
// the wait-counter width rule.
package iob_wishbone2iob_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_ACK   = 3'd2,
    ST_ERR   = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  // The counter must hold TIMEOUT; a disabled timeout still needs a 1-bit counter.
  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/iob_reg.sv
// Generic enabled register with asynchronous active-low reset to zero.
// Latency 1 cycle; holds its value whenever en_i is low.
module iob_reg #(
  parameter int DATA_W = 1
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) data_o <= '0;
    else if (en_i) data_o <= data_i;
  end

endmodule

// File: rtl/iob_wishbone2iob.sv
// Wishbone classic slave to IOb master bridge. Strobe-to-ack is 2 cycles minimum;
// an IOb request is never withdrawn, so aborts and timeouts drain via DRAIN.
module iob_wishbone2iob
  import iob_wishbone2iob_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [ADDR_W-1:0]   wb_adr_i,
  input  logic [DATA_W/8-1:0] wb_sel_i,
  input  logic [DATA_W-1:0]   wb_dat_i,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                iob_valid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic [DATA_W-1:0]   iob_rdata_i,
  input  logic                iob_ready_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = cnt_width(TIMEOUT);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   wait_cnt;
  logic               err_flag;
  logic               rst_done;
  logic               req_en;
  logic               rd_en;
  logic               timeout_hit;
  logic [STRB_W-1:0]  wstrb_in;

  assign wstrb_in    = wb_we_i ? wb_sel_i : '0;
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    req_en    = 1'b0;
    rd_en     = 1'b0;
    case (state)
      // rst_done keeps the first edge after reset release from accepting a strobe
      ST_IDLE: if (rst_done && wb_cyc_i && wb_stb_i) begin
        req_en    = 1'b1;
        state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (iob_ready_i) begin
          if (wb_cyc_i) begin
            rd_en     = ~|iob_wstrb_o;
            state_nxt = ST_ACK;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (!wb_cyc_i || timeout_hit) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_ACK:   state_nxt = ST_IDLE;
      ST_ERR:   state_nxt = ST_IDLE;
      ST_DRAIN: if (iob_ready_i) state_nxt = err_flag ? ST_ERR : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      err_flag <= 1'b0;
      rst_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      rst_done <= 1'b1;
      if (req_en) begin
        wait_cnt <= '0;
        err_flag <= 1'b0;
      end else if (state == ST_REQ && !iob_ready_i && wb_cyc_i) begin
        if (timeout_hit) err_flag <= 1'b1;
        else             wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

  assign iob_valid_o = (state == ST_REQ) || (state == ST_DRAIN);
  assign wb_ack_o    = (state == ST_ACK);
  assign wb_err_o    = (state == ST_ERR);

  iob_reg #(.DATA_W(ADDR_W)) u_addr_reg (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .en_i(req_en), .data_i(wb_adr_i), .data_o(iob_addr_o)
  );

  iob_reg #(.DATA_W(DATA_W)) u_wdata_reg (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .en_i(req_en), .data_i(wb_dat_i), .data_o(iob_wdata_o)
  );

  iob_reg #(.DATA_W(STRB_W)) u_wstrb_reg (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .en_i(req_en), .data_i(wstrb_in), .data_o(iob_wstrb_o)
  );

  iob_reg #(.DATA_W(DATA_W)) u_rdata_reg (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .en_i(rd_en), .data_i(iob_rdata_i), .data_o(wb_dat_o)
  );

endmodule

// File: tb/tb_iob_wishbone2iob.sv
// Directed bench for the Wishbone-to-IOb bridge; expected responses are queued
// when a transfer is issued and popped when the bridge acks or errors.
module tb_iob_wishbone2iob;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [31:0] wb_adr = '0, wb_dat_w = '0;
  logic [3:0]  wb_sel = '0;
  logic [31:0] wb_dat_r;
  logic        wb_ack, wb_err;
  logic        iob_valid;
  logic [31:0] iob_addr, iob_wdata, iob_rdata = '0;
  logic [3:0]  iob_wstrb;
  logic        iob_ready = 1'b0;

  typedef struct {
    logic        err;
    logic [31:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  iob_wishbone2iob #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk_i(clk), .arst_n_i(arst_n),
    .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
    .wb_adr_i(wb_adr), .wb_sel_i(wb_sel), .wb_dat_i(wb_dat_w),
    .wb_dat_o(wb_dat_r), .wb_ack_o(wb_ack), .wb_err_o(wb_err),
    .iob_valid_o(iob_valid), .iob_addr_o(iob_addr), .iob_wdata_o(iob_wdata),
    .iob_wstrb_o(iob_wstrb), .iob_rdata_i(iob_rdata), .iob_ready_i(iob_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    check("ack_err_excl", {31'b0, wb_ack & wb_err}, 32'd0);
  endtask

  task automatic quiet(input string tag);
    check({tag, "_ack"}, {31'b0, wb_ack}, 32'd0);
    check({tag, "_err"}, {31'b0, wb_err}, 32'd0);
  endtask

  task automatic resp_now(input string tag);
    exp_t e;
    check({tag, "_qdepth"}, exp_q.size(), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_ack"}, {31'b0, wb_ack}, {31'b0, ~e.err});
      check({tag, "_err"}, {31'b0, wb_err}, {31'b0, e.err});
      check({tag, "_dat"}, wb_dat_r, e.dat);
    end
  endtask

  task automatic start(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
    wb_adr = adr; wb_sel = sel; wb_dat_w = dat;
  endtask

  task automatic stop();
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_valid", {31'b0, iob_valid}, 32'd0);
    quiet("rst");
    check("rst_dat", wb_dat_r, 32'd0);
    check("rst_addr", iob_addr, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    step();

    // Read at 0x10, ready after 3 REQ cycles
    start(1'b0, 32'h10, 4'hF, 32'h0);
    exp_q.push_back('{err: 1'b0, dat: 32'hDEADBEEF});
    step();
    check("rd_valid", {31'b0, iob_valid}, 32'd1);
    check("rd_wstrb", {28'b0, iob_wstrb}, 32'd0);
    check("rd_addr", iob_addr, 32'h10);
    quiet("rd_c1");
    step(); quiet("rd_c2");
    step(); quiet("rd_c3");
    iob_ready = 1'b1; iob_rdata = 32'hDEADBEEF;
    step();
    resp_now("rd");
    iob_ready = 1'b0; iob_rdata = 32'h0; stop();
    step();
    quiet("rd_after");
    check("rd_idle_valid", {31'b0, iob_valid}, 32'd0);

    // Write with ready in the first REQ cycle; read data register must not move
    start(1'b1, 32'h20, 4'h3, 32'hA5A5A5A5);
    exp_q.push_back('{err: 1'b0, dat: 32'hDEADBEEF});
    step();
    check("wr_valid", {31'b0, iob_valid}, 32'd1);
    check("wr_wstrb", {28'b0, iob_wstrb}, 32'h3);
    check("wr_wdata", iob_wdata, 32'hA5A5A5A5);
    check("wr_addr", iob_addr, 32'h20);
    wb_dat_w = 32'h0;
    iob_ready = 1'b1; iob_rdata = 32'h12345678;
    step();
    resp_now("wr");
    check("wr_wdata_hold", iob_wdata, 32'hA5A5A5A5);
    iob_ready = 1'b0; stop();
    step();
    quiet("wr_after");

    // Timeout with ready withheld 10 cycles
    start(1'b0, 32'h30, 4'hF, 32'h0);
    exp_q.push_back('{err: 1'b1, dat: 32'hDEADBEEF});
    for (int i = 0; i < 10; i++) begin
      step();
      check("to_valid", {31'b0, iob_valid}, 32'd1);
      quiet("to_wait");
    end
    iob_ready = 1'b1; iob_rdata = 32'hBAD0BAD0;
    step();
    resp_now("to");
    iob_ready = 1'b0; stop();
    step();
    quiet("to_after");
    check("to_idle_valid", {31'b0, iob_valid}, 32'd0);

    // Master abort in REQ cycle 2, ready in cycle 5
    start(1'b0, 32'h40, 4'hF, 32'h0);
    step(); quiet("ab_c1");
    step(); quiet("ab_c2");
    stop();
    step(); check("ab_c3_valid", {31'b0, iob_valid}, 32'd1); quiet("ab_c3");
    step(); check("ab_c4_valid", {31'b0, iob_valid}, 32'd1); quiet("ab_c4");
    step(); check("ab_c5_valid", {31'b0, iob_valid}, 32'd1); quiet("ab_c5");
    iob_ready = 1'b1; iob_rdata = 32'h55555555;
    step();
    iob_ready = 1'b0;
    check("ab_idle_valid", {31'b0, iob_valid}, 32'd0);
    quiet("ab_end");
    check("ab_dat", wb_dat_r, 32'hDEADBEEF);
    step(); quiet("ab_after");

    // Back-to-back reads with strobe held
    start(1'b0, 32'h50, 4'hF, 32'h0);
    exp_q.push_back('{err: 1'b0, dat: 32'h11111111});
    step();
    iob_ready = 1'b1; iob_rdata = 32'h11111111;
    step();
    resp_now("b2b_0");
    iob_ready = 1'b0; wb_adr = 32'h54;
    exp_q.push_back('{err: 1'b0, dat: 32'h22222222});
    step();
    quiet("b2b_gap");
    check("b2b_gap_valid", {31'b0, iob_valid}, 32'd0);
    step();
    check("b2b_valid", {31'b0, iob_valid}, 32'd1);
    check("b2b_addr", iob_addr, 32'h54);
    iob_ready = 1'b1; iob_rdata = 32'h22222222;
    step();
    resp_now("b2b_1");
    iob_ready = 1'b0; stop();
    step();
    quiet("b2b_after");

    // Strobe without cycle is ignored
    wb_stb = 1'b1; wb_adr = 32'h70;
    for (int i = 0; i < 3; i++) begin
      step();
      check("nocyc_valid", {31'b0, iob_valid}, 32'd0);
    end
    stop();

    // Reset pulsed during REQ, then the held strobe is serviced normally
    start(1'b0, 32'h60, 4'hF, 32'h0);
    step();
    check("rr_valid", {31'b0, iob_valid}, 32'd1);
    #2 arst_n = 1'b0;
    #1;
    check("rr_async_valid", {31'b0, iob_valid}, 32'd0);
    quiet("rr_async");
    check("rr_async_addr", iob_addr, 32'd0);
    check("rr_async_dat", wb_dat_r, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    step();
    check("rr_first_edge_valid", {31'b0, iob_valid}, 32'd0);
    step();
    check("rr_restart_valid", {31'b0, iob_valid}, 32'd1);
    check("rr_restart_addr", iob_addr, 32'h60);
    exp_q.push_back('{err: 1'b0, dat: 32'hCAFEF00D});
    iob_ready = 1'b1; iob_rdata = 32'hCAFEF00D;
    step();
    resp_now("rr");
    iob_ready = 1'b0; stop();
    step();
    quiet("rr_after");

    check("sb_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
